clock_edge_tracker: RTL and testbench

Receiving-side counterpart to the on-chip power-of-two clock dividers. Takes an externally generated slow clock (codec bit/word clock, a divided clock from another domain), synchronises it into `clk_in`, and produces one-cycle rising/falling strobes. It also measures the period in `clk_in` cycles and reports lock/loss. It sits at the boundary between external timing sources and the audio/video pipelines that consume strobes rather than raw clocks.

---
 rtl/clock_edge_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_clock_edge_tracker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_edge_tracker.sv
`default_nettype none
// ============================================================================
// Module      : clock_edge_tracker
// Description : Brings an external slow clock (codec bit/word clock or a
//               divided clock from another domain) into the clk_in domain.
//               Produces one-cycle rising/falling strobes, measures the
//               rising-to-rising period in clk_in cycles and tracks
//               lock / loss of the external clock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   CLOCK_EDGE_TRACKER_DEGLITCH_EN - when defined, a run-length filter sits
//   after the synchroniser; clk_sync only follows a level that the last
//   synchroniser stage has held for DeglitchCycles consecutive cycles.
//
// Parameters:
//   SyncStages     - synchroniser depth on clk_ext (2..4)
//   PeriodWidth    - width of the elapsed counter and the period output
//   TimeoutCycles  - clk_in cycles without a rising strobe before loss
//                    (2 .. 2^PeriodWidth-1)
//   DeglitchCycles - filter length when the filter is compiled in (1..15)
//
// Ports:
//   clk_in       in   system clock
//   rst          in   asynchronous, active-high reset
//   clk_ext      in   external clock, asynchronous to clk_in
//   clk_sync     out  synchronised (optionally filtered) clk_ext
//   clk_rising   out  one-cycle strobe on a 0->1 of clk_sync
//   clk_falling  out  one-cycle strobe on a 1->0 of clk_sync
//   period       out  last measured rising-to-rising interval
//   period_valid out  one-cycle pulse when period is updated
//   locked       out  high while consecutive periods are being measured
//   timeout      out  one-cycle pulse when loss of clk_ext is declared
// ============================================================================
module clock_edge_tracker #(
  parameter int SyncStages     = 2,
  parameter int PeriodWidth    = 16,
  parameter int TimeoutCycles  = 65535,
  parameter int DeglitchCycles = 2
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   clk_ext,
  output logic                   clk_sync,
  output logic                   clk_rising,
  output logic                   clk_falling,
  output logic [PeriodWidth-1:0] period,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   timeout
);

  localparam logic [PeriodWidth-1:0] c_TIMEOUT = PeriodWidth'(TimeoutCycles);
  localparam logic [PeriodWidth-1:0] c_ONE     = PeriodWidth'(1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter guards
  // --------------------------------------------------------------------------
  if (SyncStages < 2 || SyncStages > 4) begin : g_bad_sync_stages
    $error("clock_edge_tracker: SyncStages must be in 2..4");
  end
  if (TimeoutCycles < 2 || TimeoutCycles > (2 ** PeriodWidth) - 1) begin : g_bad_timeout
    $error("clock_edge_tracker: TimeoutCycles out of range for PeriodWidth");
  end
  if (DeglitchCycles < 1 || DeglitchCycles > 15) begin : g_bad_deglitch
    $error("clock_edge_tracker: DeglitchCycles must be in 1..15");
  end

  // --------------------------------------------------------------------------
  // Synchroniser chain: bit 0 samples clk_ext, the top bit is the safe copy.
  // --------------------------------------------------------------------------
  logic [SyncStages-1:0] sync_q;
  logic                  sync_last;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], clk_ext};
    end
  end

  assign sync_last = sync_q[SyncStages-1];

  // --------------------------------------------------------------------------
  // Optional run-length deglitch filter
  // --------------------------------------------------------------------------
  logic sync_level;

`ifdef CLOCK_EDGE_TRACKER_DEGLITCH_EN
  logic       filt_q;
  logic [3:0] run_q;

  // run_q counts consecutive cycles the synchroniser output has disagreed
  // with the filtered level; the level flips on the DeglitchCycles-th one.
  // Any return to the current level before that discards the run.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      run_q  <= 4'd0;
    end else if (sync_last == filt_q) begin
      run_q <= 4'd0;
    end else if (run_q == 4'(DeglitchCycles - 1)) begin
      filt_q <= sync_last;
      run_q  <= 4'd0;
    end else begin
      run_q <= run_q + 4'd1;
    end
  end

  assign sync_level = filt_q;
`else
  assign sync_level = sync_last;
`endif

  // --------------------------------------------------------------------------
  // Edge strobes: combinational from two registers, so they are one cycle
  // wide and can never be high together.
  // --------------------------------------------------------------------------
  logic clk_sync_dly_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      clk_sync_dly_q <= 1'b0;
    end else begin
      clk_sync_dly_q <= sync_level;
    end
  end

  assign clk_sync    = sync_level;
  assign clk_rising  =  sync_level & ~clk_sync_dly_q;
  assign clk_falling = ~sync_level &  clk_sync_dly_q;

  // --------------------------------------------------------------------------
  // Elapsed counter: restarts at 1 after each rising strobe, so during the
  // next strobe cycle it already holds the rising-to-rising distance.
  // --------------------------------------------------------------------------
  logic [PeriodWidth-1:0] elapsed_q;
  logic [PeriodWidth-1:0] elapsed_d;

  always_comb begin
    elapsed_d = elapsed_q;
    if (clk_rising) begin
      elapsed_d = c_ONE;
    end else if (elapsed_q != c_TIMEOUT) begin
      elapsed_d = elapsed_q + c_ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Lock FSM with registered outputs. A strobe coinciding with a saturated
  // counter is treated as a valid period, not a loss.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_MEASURING = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [PeriodWidth-1:0] period_q;
  logic                   period_valid_q;
  logic                   locked_q;
  logic                   timeout_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q        <= ST_UNLOCKED;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      case (state_q)
        ST_UNLOCKED: begin
          if (clk_rising) begin
            state_q <= ST_MEASURING;
          end
        end
        ST_MEASURING, ST_LOCKED: begin
          if (clk_rising) begin
            state_q        <= ST_LOCKED;
            locked_q       <= 1'b1;
            period_q       <= elapsed_q;
            period_valid_q <= 1'b1;
          end else if (elapsed_q == c_TIMEOUT) begin
            state_q   <= ST_UNLOCKED;
            locked_q  <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_UNLOCKED;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_edge_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_edge_tracker
// Description : Scoreboard bench for clock_edge_tracker. The stimulus side
//               drives clk_ext one clk_in cycle at a time and, from the list
//               of input edge times, predicts every strobe, period publish,
//               lock change and timeout into queues. A monitor compares the
//               DUT against those queues every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_edge_tracker;

  localparam int S  = 2;
  localparam int PW = 16;
  localparam int T  = 50;
  localparam int DG = 3;
`ifdef CLOCK_EDGE_TRACKER_DEGLITCH_EN
  localparam int DGL  = DG;
  localparam int MINW = 4;
`else
  localparam int DGL  = 0;
  localparam int MINW = 2;
`endif
  // Input level sampled at posedge t appears as a strobe in cycle t+LAT_R;
  // registered consequences (period, lock, timeout) appear at t+LAT_P.
  localparam int LAT_R = S - 1 + DGL;
  localparam int LAT_P = S + DGL;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b0;
  logic          clk_ext = 1'b0;
  logic          clk_sync, clk_rising, clk_falling;
  logic [PW-1:0] period;
  logic          period_valid, locked, timeout;

  clock_edge_tracker #(
    .SyncStages    (S),
    .PeriodWidth   (PW),
    .TimeoutCycles (T),
    .DeglitchCycles(DG)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .clk_ext     (clk_ext),
    .clk_sync    (clk_sync),
    .clk_rising  (clk_rising),
    .clk_falling (clk_falling),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  int  rq[$];
  int  fq[$];
  int  toq[$];
  ev_t pvq[$];
  ev_t lkq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: works purely on input rising-edge times.
  // --------------------------------------------------------------------------
  bit m_prev   = 1'b0;
  bit m_active = 1'b0;
  bit m_locked = 1'b0;
  int m_last   = 0;

  task automatic model_step(input int t, input bit lvl);
    if (lvl && !m_prev) begin
      rq.push_back(t + LAT_R);
      if (m_active) begin
        pvq.push_back('{t + LAT_P, t - m_last});
        if (!m_locked) begin
          lkq.push_back('{t + LAT_P, 1});
          m_locked = 1'b1;
        end
      end
      m_active = 1'b1;
      m_last   = t;
    end else begin
      if (!lvl && m_prev) fq.push_back(t + LAT_R);
      if (m_active && (t - m_last) == T) begin
        toq.push_back(t + LAT_P);
        if (m_locked) begin
          lkq.push_back('{t + LAT_P, 0});
          m_locked = 1'b0;
        end
        m_active = 1'b0;
      end
    end
    m_prev = lvl;
  endtask

  // Drive lvl onto clk_ext for n cycles while the model sees mlvl (they
  // differ only for pulses the filter is expected to swallow).
  task automatic drive_raw(input bit lvl, input bit mlvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      clk_ext = lvl;
      model_step(cyc + 1, mlvl);
    end
  endtask

  task automatic drive(input bit lvl, input int n);
    drive_raw(lvl, lvl, n);
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    check("rst_clk_sync",     {31'd0, clk_sync},     0);
    check("rst_rising",       {31'd0, clk_rising},   0);
    check("rst_falling",      {31'd0, clk_falling},  0);
    check("rst_period",       {16'd0, period},       0);
    check("rst_period_valid", {31'd0, period_valid}, 0);
    check("rst_locked",       {31'd0, locked},       0);
    check("rst_timeout",      {31'd0, timeout},      0);
    rq.delete(); fq.delete(); toq.delete(); pvq.delete(); lkq.delete();
    m_active = 1'b0;
    m_locked = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [PW-1:0] exp_period = '0;
  bit            exp_locked = 1'b0;

  initial begin
    bit er, ef, ep, et;
    forever begin
      @(posedge clk_in);
      #1;
      if (rst) begin
        exp_period = '0;
        exp_locked = 1'b0;
        check("reset_outputs",
              {25'd0, clk_sync, clk_rising, clk_falling, period_valid, locked, timeout, |period}, 0);
      end else begin
        er = (rq.size() > 0) && (rq[0] == cyc);
        if (er) void'(rq.pop_front());
        check("clk_rising", {31'd0, clk_rising}, {31'd0, er});

        ef = (fq.size() > 0) && (fq[0] == cyc);
        if (ef) void'(fq.pop_front());
        check("clk_falling", {31'd0, clk_falling}, {31'd0, ef});

        check("strobe_exclusive", {31'd0, clk_rising & clk_falling}, 0);

        ep = (pvq.size() > 0) && (pvq[0].cyc == cyc);
        if (ep) begin
          exp_period = PW'(pvq[0].val);
          void'(pvq.pop_front());
        end
        check("period_valid", {31'd0, period_valid}, {31'd0, ep});
        check("period", {16'd0, period}, {16'd0, exp_period});

        et = (toq.size() > 0) && (toq[0] == cyc);
        if (et) void'(toq.pop_front());
        check("timeout", {31'd0, timeout}, {31'd0, et});

        if ((lkq.size() > 0) && (lkq[0].cyc == cyc)) begin
          exp_locked = (lkq[0].val != 0);
          void'(lkq.pop_front());
        end
        check("locked", {31'd0, locked}, {31'd0, exp_locked});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int h, l, n;
    rst     = 1'b1;
    clk_ext = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;

    drive(1'b0, 5);
    wave(10, 10, 6);          // square wave, period 20
    wave(7, 13, 5);           // 7 high / 13 low, period 20
    drive(1'b0, 60);          // stop while locked -> timeout
    wave(10, 10, 3);          // restart: first edge silent, second publishes
    wave(25, 25, 3);          // period exactly TimeoutCycles
    wave(10, 10, 3);
    pulse_reset();            // reset while locked, clk_ext low and settled
    drive(1'b0, 5);
    wave(10, 10, 3);

`ifdef CLOCK_EDGE_TRACKER_DEGLITCH_EN
    drive(1'b0, 10);
    drive_raw(1'b1, 1'b0, 2); // 2-cycle glitch, must be swallowed
    drive(1'b0, 10);
    drive(1'b1, 4);           // 4-cycle pulse passes with extra latency
    drive(1'b0, 10);
`endif

    for (int s = 0; s < 25; s++) begin
      h = $urandom_range(30, MINW);
      l = $urandom_range(30, MINW);
      n = $urandom_range(4, 1);
      wave(h, l, n);
    end

    drive(1'b0, T + 10);
    repeat (LAT_P + 3) @(negedge clk_in);
    check("queues_drained", rq.size() + fq.size() + pvq.size() + toq.size() + lkq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
